// File: rtl/td4_decode_stage_if.sv
// Fetch-side and execute-side valid/ready channels of the TD4 decode stage.
// The slave modport is the stage's view, and the master modport is the view from its surroundings.
interface td4_decode_stage_if #(
  parameter int IMM_W = 4,
  parameter int PC_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W+3:0]  in_inst;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [IMM_W-1:0]  out_imm;
  logic [1:0]        out_src;
  logic [1:0]        out_dst;
  logic              out_wr;
  logic              out_cond_nc;
  logic              out_carry_we;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_src, out_dst,
           out_wr, out_cond_nc, out_carry_we, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_src, out_dst,
           out_wr, out_cond_nc, out_carry_we, out_illegal
  );
endinterface

// File: rtl/td4_decode_stage.sv
// TD4 decode pipeline stage: decodes on accept into an output register (M) with a one-entry skid (S).
// Illegal opcodes travel on as bubbles without write enables and feed a saturating counter.
module td4_decode_stage #(
  parameter int IMM_W = 4,
  parameter int PC_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  td4_decode_stage_if.slave bus,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             illegal_sticky
);
  localparam int INST_W = IMM_W + 4;
  localparam int CW     = IMM_W + 8;
  localparam int DW     = PC_W + CW;
  localparam logic [1:0] SRC_A = 2'b00, SRC_B = 2'b01, SRC_IN = 2'b10, SRC_Z = 2'b11;
  localparam logic [1:0] DST_A = 2'b00, DST_B = 2'b01, DST_OUT = 2'b10, DST_PC = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Bundle layout, from MSB to LSB: {illegal, carry_we, cond_nc, wr, dst, src, imm}
  function automatic logic [CW-1:0] decode(input logic [INST_W-1:0] inst);
    logic       ill, cwe, cnc, wr, use_imm;
    logic [1:0] src, dst;
    ill = 1'b0; cwe = 1'b1; cnc = 1'b0; wr = 1'b1; use_imm = 1'b0;
    src = SRC_A; dst = DST_A;
    case (inst[INST_W-1 -: 4])
      4'b0000: begin src = SRC_A;  dst = DST_A;   use_imm = 1'b1; end
      4'b0101: begin src = SRC_B;  dst = DST_B;   use_imm = 1'b1; end
      4'b0011: begin src = SRC_Z;  dst = DST_A;   use_imm = 1'b1; end
      4'b0111: begin src = SRC_Z;  dst = DST_B;   use_imm = 1'b1; end
      4'b0001: begin src = SRC_B;  dst = DST_A;   end
      4'b0100: begin src = SRC_A;  dst = DST_B;   end
      4'b0010: begin src = SRC_IN; dst = DST_A;   end
      4'b0110: begin src = SRC_IN; dst = DST_B;   end
      4'b1001: begin src = SRC_B;  dst = DST_OUT; end
      4'b1011: begin src = SRC_Z;  dst = DST_OUT; use_imm = 1'b1; end
      4'b1111: begin src = SRC_Z;  dst = DST_PC;  use_imm = 1'b1; cwe = 1'b0; end
      4'b1110: begin src = SRC_Z;  dst = DST_PC;  use_imm = 1'b1; cwe = 1'b0; cnc = 1'b1; end
      default: begin ill = 1'b1;   wr = 1'b0;     cwe = 1'b0; end
    endcase
    return {ill, cwe, cnc, wr, dst, src, (use_imm ? inst[IMM_W-1:0] : {IMM_W{1'b0}})};
  endfunction

  logic          m_valid_r, s_valid_r, in_ready_r, sticky_r;
  logic [DW-1:0] m_data_r, s_data_r;
  logic [CNT_W-1:0] cnt_r;
  logic          m_valid_s, s_valid_s, accept_s, fire_s, count_s;
  logic [DW-1:0] m_data_s, s_data_s, in_data_s;

  // Next-state logic for the M/S pair: S always drains into M before new input is taken
  always_comb begin
    accept_s  = bus.in_valid & in_ready_r;
    fire_s    = m_valid_r & bus.out_ready;
    in_data_s = {bus.in_pc, decode(bus.in_inst)};
    m_valid_s = m_valid_r;
    m_data_s  = m_data_r;
    s_valid_s = s_valid_r;
    s_data_s  = s_data_r;
    if (flush) begin
      m_valid_s = 1'b0;
      s_valid_s = 1'b0;
    end else if (!m_valid_r || fire_s) begin
      if (s_valid_r) begin
        m_valid_s = 1'b1;
        m_data_s  = s_data_r;
        s_valid_s = 1'b0;
      end else if (accept_s) begin
        m_valid_s = 1'b1;
        m_data_s  = in_data_s;
      end else begin
        m_valid_s = 1'b0;
      end
    end else if (accept_s) begin
      s_valid_s = 1'b1;
      s_data_s  = in_data_s;
    end else begin
      s_valid_s = s_valid_r;
    end
    count_s = accept_s & ~flush & in_data_s[CW-1] & (cnt_r != CNT_MAX);
  end

  // State registers; in_ready is registered from the next skid occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_r  <= 1'b0;
      s_valid_r  <= 1'b0;
      m_data_r   <= {DW{1'b0}};
      s_data_r   <= {DW{1'b0}};
      in_ready_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      sticky_r   <= 1'b0;
    end else begin
      m_valid_r  <= m_valid_s;
      s_valid_r  <= s_valid_s;
      m_data_r   <= m_data_s;
      s_data_r   <= s_data_s;
      in_ready_r <= ~s_valid_s;
      if (count_s) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
      sticky_r <= sticky_r | (accept_s & ~flush & in_data_s[CW-1]);
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.out_valid    = m_valid_r;
  assign bus.out_pc       = m_data_r[DW-1 -: PC_W];
  assign bus.out_illegal  = m_data_r[IMM_W+7];
  assign bus.out_carry_we = m_data_r[IMM_W+6];
  assign bus.out_cond_nc  = m_data_r[IMM_W+5];
  assign bus.out_wr       = m_data_r[IMM_W+4];
  assign bus.out_dst      = m_data_r[IMM_W+3 -: 2];
  assign bus.out_src      = m_data_r[IMM_W+1 -: 2];
  assign bus.out_imm      = m_data_r[IMM_W-1:0];
  assign illegal_cnt      = cnt_r;
  assign illegal_sticky   = sticky_r;
endmodule

// File: tb/tb_td4_decode_stage.sv
// Scoreboard bench for td4_decode_stage: reference decodes are queued on accept and compared on fire.
// CNT_W is 2 here so that the counter reaches saturation within a few instructions.
module tb_td4_decode_stage;
  localparam int IMM_W = 4;
  localparam int PC_W  = 4;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [CNT_W-1:0] illegal_cnt;
  logic illegal_sticky;
  int n_cmp = 0;
  int n_err = 0;

  td4_decode_stage_if #(.IMM_W(IMM_W), .PC_W(PC_W)) bus ();

  td4_decode_stage #(.IMM_W(IMM_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .illegal_cnt(illegal_cnt), .illegal_sticky(illegal_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference bundle {pc, ill, carry_we, cond_nc, wr, dst, src, imm}; src/dst codes come from the opcode table
  function automatic logic [15:0] model(input logic [7:0] inst, input logic [3:0] pc);
    logic [3:0] im;
    im = inst[3:0];
    case (inst[7:4])
      4'h0: return {pc, 4'b0101, 2'd0, 2'd0, im};
      4'h5: return {pc, 4'b0101, 2'd1, 2'd1, im};
      4'h3: return {pc, 4'b0101, 2'd0, 2'd3, im};
      4'h7: return {pc, 4'b0101, 2'd1, 2'd3, im};
      4'h1: return {pc, 4'b0101, 2'd0, 2'd1, 4'h0};
      4'h4: return {pc, 4'b0101, 2'd1, 2'd0, 4'h0};
      4'h2: return {pc, 4'b0101, 2'd0, 2'd2, 4'h0};
      4'h6: return {pc, 4'b0101, 2'd1, 2'd2, 4'h0};
      4'h9: return {pc, 4'b0101, 2'd2, 2'd1, 4'h0};
      4'hB: return {pc, 4'b0101, 2'd2, 2'd3, im};
      4'hF: return {pc, 4'b0001, 2'd3, 2'd3, im};
      4'hE: return {pc, 4'b0011, 2'd3, 2'd3, im};
      default: return {pc, 4'b1000, 2'd0, 2'd0, 4'h0};
    endcase
  endfunction

  function automatic logic [15:0] obs();
    return {bus.out_pc, bus.out_illegal, bus.out_carry_we, bus.out_cond_nc, bus.out_wr,
            bus.out_dst, bus.out_src, bus.out_imm};
  endfunction

  logic [15:0] exp_q[$];
  logic [15:0] exp_e;
  logic [15:0] held;
  logic [CNT_W-1:0] cnt_exp = 2'd0;
  logic sticky_exp = 1'b0;
  logic stall_prev = 1'b0;

  always @(negedge clk) begin
    chk("illegal_cnt", 32'(illegal_cnt), 32'(cnt_exp));
    chk("illegal_sticky", 32'(illegal_sticky), 32'(sticky_exp));
    if (stall_prev) chk("stable_while_stalled", 32'(obs()), 32'(held));
    if (bus.out_valid && bus.out_ready) begin
      chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        chk("bundle", 32'(obs()), 32'(exp_e));
      end
    end
    if (rst) begin
      exp_q.delete();
      cnt_exp = 2'd0;
      sticky_exp = 1'b0;
      stall_prev = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_e = model(bus.in_inst, bus.in_pc);
        exp_q.push_back(exp_e);
        if (exp_e[11]) begin
          sticky_exp = 1'b1;
          if (cnt_exp != 2'd3) cnt_exp = cnt_exp + 2'd1;
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = obs();
    end
  end

  task automatic send(input logic [7:0] inst, input logic [3:0] pc);
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  logic done = 1'b0;

  initial begin
    bus.in_valid = 1'b0; bus.in_inst = 8'h00; bus.in_pc = 4'h0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_data", 32'(obs()), 32'd0);

    // ADD A,3 with one-cycle latency
    bus.out_ready = 1'b1;
    send(8'h03, 4'h1);
    bus.in_valid = 1'b0;
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_src_dst", 32'({bus.out_src, bus.out_dst}), 32'h0);
    chk("t1_imm", 32'(bus.out_imm), 32'd3);
    chk("t1_wr_cwe", 32'({bus.out_wr, bus.out_carry_we}), 32'h3);
    idle();

    // Back-pressure fills M then S, then releases in order
    bus.out_ready = 1'b0;
    send(8'h31, 4'h2);
    send(8'h72, 4'h3);
    chk("t2_full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1; bus.in_inst = 8'h95; bus.in_pc = 4'h4;
    repeat (2) begin @(posedge clk); #1; end
    chk("t2_still_blocked", 32'(bus.in_ready), 32'd0);
    chk("t2_head_pc", 32'(bus.out_pc), 32'h2);
    bus.out_ready = 1'b1;
    send(8'h95, 4'h4);
    repeat (3) idle();
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // Jumps
    send(8'hE7, 4'h5);
    bus.in_valid = 1'b0;
    chk("t3_jnc", 32'({bus.out_dst, bus.out_imm, bus.out_cond_nc, bus.out_carry_we}), 32'({2'd3, 4'd7, 1'b1, 1'b0}));
    send(8'hF2, 4'h6);
    bus.in_valid = 1'b0;
    chk("t3_jmp", 32'({bus.out_dst, bus.out_imm, bus.out_cond_nc, bus.out_carry_we}), 32'({2'd3, 4'd2, 1'b0, 1'b0}));
    idle();

    // Illegal opcodes
    send(8'h8A, 4'h7);
    bus.in_valid = 1'b0;
    chk("t4_ill_8", 32'({bus.out_illegal, bus.out_wr}), 32'h2);
    send(8'hC5, 4'h8);
    bus.in_valid = 1'b0;
    chk("t4_ill_c", 32'({bus.out_illegal, bus.out_wr}), 32'h2);
    idle();
    chk("t4_cnt2", 32'(illegal_cnt), 32'd2);
    chk("t4_sticky", 32'(illegal_sticky), 32'd1);

    // Flush with M and S full, then flush discarding an accepted illegal
    bus.out_ready = 1'b0;
    send(8'h11, 4'h9);
    send(8'h22, 4'hA);
    bus.in_valid = 1'b1; bus.in_inst = 8'hA5; bus.in_pc = 4'hB; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t5_cnt", 32'(illegal_cnt), 32'd2);
    bus.in_valid = 1'b1; bus.in_inst = 8'hD1; bus.in_pc = 4'hC; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("t5_discard_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_discard_cnt", 32'(illegal_cnt), 32'd2);

    // Saturation
    bus.out_ready = 1'b1;
    send(8'h80, 4'h1); send(8'hA0, 4'h2); send(8'hC0, 4'h3); send(8'hD0, 4'h4); send(8'h81, 4'h5);
    idle();
    chk("t4_cnt_sat", 32'(illegal_cnt), 32'd3);

    // Random stream with random back-pressure
    fork
      begin
        for (int i = 0; i < 40; i++) send(8'($urandom_range(0, 255)), 4'(i));
        bus.in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #2;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (5) idle();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-transfer
    bus.out_ready = 1'b0;
    send(8'h03, 4'h1);
    send(8'h04, 4'h2);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t6_cnt", 32'(illegal_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("t6_out_valid_after", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
